// File: rtl/compl_arb_pkg.sv
// Shared definitions for the compl_arb slice: FSM state encoding, datapath
// widths and the default WAIT timeout.
package compl_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10,
        ARB_RESP  = 2'b11
    } arb_state_e;

    localparam int ANGLE_W     = 12;
    localparam int DATA_W      = 16;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/compl_arb_if.sv
// Bus between the DSP clients, the arbiter and the shared cos/sin generator.
//
// Handshakes:
//   client side : req[k] is a level held until done[k] pulses for one cycle;
//                 res_r/res_i/res_id/res_err are valid only while done != 0.
//   generator   : gen_start is a one-cycle pulse with gen_angle valid; the
//                 generator answers with gen_ready (result valid) carrying
//                 gen_r/gen_i. The arbiter samples gen_ready only while it is
//                 waiting for a result.
//
// Modports:
//   slave  - the arbiter (serves requests, drives the generator)
//   master - clients plus generator model (drive req and the results)
interface compl_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]                         req;
    logic [NREQ*compl_arb_pkg::ANGLE_W-1:0]  req_angle;
    logic [NREQ-1:0]                         gnt;
    logic [NREQ-1:0]                         done;
    logic [compl_arb_pkg::DATA_W-1:0]        res_r;
    logic [compl_arb_pkg::DATA_W-1:0]        res_i;
    logic [IDW-1:0]                          res_id;
    logic                                    res_err;
    logic                                    gen_start;
    logic [compl_arb_pkg::ANGLE_W-1:0]       gen_angle;
    logic                                    gen_ready;
    logic [compl_arb_pkg::DATA_W-1:0]        gen_r;
    logic [compl_arb_pkg::DATA_W-1:0]        gen_i;

    modport slave (
        input  req, req_angle, gen_ready, gen_r, gen_i,
        output gnt, done, res_r, res_i, res_id, res_err, gen_start, gen_angle
    );

    modport master (
        output req, req_angle, gen_ready, gen_r, gen_i,
        input  gnt, done, res_r, res_i, res_id, res_err, gen_start, gen_angle
    );
endinterface

// File: rtl/compl_arb_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req   - request vector
//   ptr   - highest-priority index this round
//   gnt   - one-hot grant of the first requester at or after ptr (wrapping)
//   id    - index of the granted requester
//   valid - any request present
module compl_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  id,
    output logic            valid
);

    always_comb begin
        int idx;
        gnt   = '0;
        id    = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr is always < NREQ, so a single subtract implements the wrap
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                id       = IDW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/compl_arb.sv
// Round-robin arbiter/sequencer sharing one cos/sin generator among NREQ
// requesters. A winner's angle is latched, issued to the generator, and the
// result is returned to that requester with a one-cycle done pulse.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset (generator shares it)
//   bus       - compl_arb_if.slave: client req/result and generator handshake
//   dbg_state - current FSM state
//
// Optional build macro COMPL_ARB_TIMEOUT_EN: bounds WAIT to TIMEOUT cycles and
// answers with res_err=1, zero data. Without it WAIT is unbounded and res_err
// is tied low.
//
// All outputs are registered and computed from the next state, so each output
// is valid in the same cycle as the state it belongs to (gen_start is high
// exactly while the FSM is in ISSUE).
module compl_arb
    import compl_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    compl_arb_if.slave bus,
    output arb_state_e dbg_state
);

    arb_state_e          state, state_next;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [NREQ-1:0]     id_onehot;

    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [DATA_W-1:0]   res_r_q, res_r_d;
    logic [DATA_W-1:0]   res_i_q, res_i_d;
    logic [IDW-1:0]      res_id_q, res_id_d;
    logic                gen_start_q, gen_start_d;
    logic [ANGLE_W-1:0]  gen_angle_q, gen_angle_d;

    logic [NREQ-1:0]     pick_gnt;
    logic [IDW-1:0]      pick_id;
    logic                pick_valid;

`ifdef COMPL_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                res_err_q, res_err_d;
`endif

    compl_arb_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .id    (pick_id),
        .valid (pick_valid)
    );

    always_comb begin
        id_onehot       = '0;
        id_onehot[id_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            res_r_q     <= '0;
            res_i_q     <= '0;
            res_id_q    <= '0;
            gen_start_q <= 1'b0;
            gen_angle_q <= '0;
`ifdef COMPL_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            res_r_q     <= res_r_d;
            res_i_q     <= res_i_d;
            res_id_q    <= res_id_d;
            gen_start_q <= gen_start_d;
            gen_angle_q <= gen_angle_d;
`ifdef COMPL_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        ptr_d       = ptr_q;
        id_d        = id_q;
        gnt_d       = '0;
        done_d      = '0;
        res_r_d     = '0;
        res_i_d     = '0;
        res_id_d    = '0;
        gen_start_d = 1'b0;
        gen_angle_d = '0;
`ifdef COMPL_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        res_err_d   = 1'b0;
`endif
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    // gen_angle_q doubles as the latched angle until RESP ends,
                    // so later req_angle changes cannot reach the generator
                    state_next  = ARB_ISSUE;
                    id_d        = pick_id;
                    gnt_d       = pick_gnt;
                    gen_start_d = 1'b1;
                    gen_angle_d = bus.req_angle[int'(pick_id)*ANGLE_W +: ANGLE_W];
                end
            end
            ARB_ISSUE: begin
                state_next  = ARB_WAIT;
                gnt_d       = id_onehot;
                gen_angle_d = gen_angle_q;
`ifdef COMPL_ARB_TIMEOUT_EN
                cnt_d       = '0;
`endif
            end
            ARB_WAIT: begin
                gnt_d       = id_onehot;
                gen_angle_d = gen_angle_q;
                if (bus.gen_ready) begin
                    state_next = ARB_RESP;
                    done_d     = id_onehot;
                    res_r_d    = bus.gen_r;
                    res_i_d    = bus.gen_i;
                    res_id_d   = id_q;
                end
`ifdef COMPL_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // TIMEOUT full WAIT cycles without a result: abort
                    state_next = ARB_RESP;
                    done_d     = id_onehot;
                    res_id_d   = id_q;
                    res_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ARB_RESP: begin
                // the served requester drops to lowest priority next round
                state_next = ARB_IDLE;
                ptr_d      = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.res_r     = res_r_q;
    assign bus.res_i     = res_i_q;
    assign bus.res_id    = res_id_q;
    assign bus.gen_start = gen_start_q;
    assign bus.gen_angle = gen_angle_q;
`ifdef COMPL_ARB_TIMEOUT_EN
    assign bus.res_err   = res_err_q;
`else
    assign bus.res_err   = 1'b0;
`endif
    assign dbg_state     = state;

endmodule

// File: doc/compl_arb.md
Name: compl_arb

Overview:
- Round-robin arbiter and sequencer that shares one complex-number generator (cos/sin unit with start/ready handshake) among NREQ requesters.
- Latches the winning requester's angle, drives the generator's start/angle, waits for ready, then returns r/i to that requester with a one-cycle done pulse.
- Sits between the DSP clients (mixers, NCO users) and the single generator instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id, ceil(log2(NREQ)).
- TIMEOUT, 15, maximum WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester level request; held until its done pulse.
- req_angle  input  NREQ*12  packed angles; requester k occupies bits [12k+11:12k].
- gnt  output  NREQ  one-hot; high for the granted requester from ISSUE through RESP.
- done  output  NREQ  one-hot, one-cycle pulse in RESP.
- res_r  output  16  real result, valid while done is nonzero.
- res_i  output  16  imaginary result, valid while done is nonzero.
- res_id  output  IDW  id of the completed requester, valid with done.
- res_err  output  1  timeout abort flag, valid with done.
- gen_start  output  1  one-cycle start pulse to the generator.
- gen_angle  output  12  angle to the generator; held constant from ISSUE until the return to IDLE.
- gen_ready  input  1  generator result-valid.
- gen_r  input  16  generator real output.
- gen_i  input  16  generator imaginary output.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0. Reset mid-transaction discards the in-flight result and issues no done pulse. The generator shares the same reset.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If any req is high, select the first requester at or after the pointer, searching upward with wrap at NREQ-1 to 0.
  - Latch its id and angle. Next state is ISSUE.
  - With no req, stay in IDLE.
- ISSUE (1 cycle):
  - gen_start=1, gen_angle=latched angle, gnt[id]=1.
  - Next state is WAIT.
- WAIT:
  - gen_start=0.
  - gen_ready is sampled only in this state; ready in any other state is ignored.
  - On gen_ready=1, capture gen_r/gen_i. Next state is RESP.
- RESP (1 cycle):
  - done[id]=1, res_r/res_i/res_id driven, gnt[id] stays 1.
  - Pointer becomes id+1 mod NREQ. Next state is IDLE.
  - done, res_* and gen_angle return to 0 in IDLE.
- Timing:
  - done occurs exactly 1 cycle after gen_ready is sampled.
  - Minimum spacing between gen_start pulses is gen latency + 3 cycles.
  - Req-to-start latency is 2 cycles when the arbiter is idle.
- Boundary conditions:
  - Simultaneous requests: strict round robin. A requester holding req after its done pulse is served only after every other pending requester.
  - Single requester: repeatedly served, pointer wraps.
  - req dropped mid-transaction: the transaction still completes and done is still pulsed.
  - req_angle changes after latch: ignored.
  - gen_ready high in the same cycle as gen_start: not sampled. WAIT begins the cycle after ISSUE.

Optional Feature:
- Macro: COMPL_ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit (or wider, to hold TIMEOUT) WAIT cycle counter clears on entry to WAIT.
  - If the count reaches TIMEOUT without gen_ready, go to RESP with res_err=1 and res_r=res_i=0.
  - A subsequent stray gen_ready is ignored.
- Undefined: no counter, WAIT is unbounded, and res_err is tied to 0. The port list is identical either way.

Decomposition:
- Shared package/header holds:
  - state encodings ARB_IDLE=2'b00, ARB_ISSUE=2'b01, ARB_WAIT=2'b10, ARB_RESP=2'b11;
  - ANGLE_W=12, DATA_W=16;
  - default TIMEOUT.
- One natural sub-module, rr_pick: combinational round-robin priority selector (req vector and pointer in; one-hot grant, id and valid out).

Test Plan:
- Bench generator stub: ready 3 cycles after start, r={4'h0,angle}, i=~r. Single request: req=4'b0001, angle0=12'h123 → gen_start 2 cycles later with gen_angle=12'h123; done=4'b0001, res_r=16'h0123, res_i=16'hFEDC, res_id=0.
- All four requesting continuously, angles 12'h010/020/030/040 → done order id 0,1,2,3,0, with correct angle-derived results each time.
- req0 held high after its done while req2 is pending → req2 served next, then req0.
- Reset asserted in WAIT → all outputs 0 asynchronously; no done pulse; next request is arbitrated from pointer 0.
- Stray gen_ready pulse in IDLE and a req_angle change during WAIT → no effect; result matches the latched angle.
- With COMPL_ARB_TIMEOUT_EN defined and the stub never asserting ready → done 1 cycle after 15 WAIT cycles, with res_err=1 and res_r=res_i=0.
